// File: rtl/set_pkg.sv
// Shared types and helpers for the SET query scheduler: mode and error
// encodings, grid limits and the operand bundle carried through the request FIFO.
package set_pkg;

   typedef enum logic [1:0] {
      MODE_A    = 2'd0,
      MODE_AND  = 2'd1,
      MODE_XOR  = 2'd2,
      MODE_TWO3 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_RANGE   = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_e;

   localparam logic [3:0] GRID_MIN = 4'd1;
   localparam logic [3:0] GRID_MAX = 4'd8;

   // Engine operands; the tag travels beside this struct so TAG_W can stay a top parameter.
   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      mode_e       mode;
   } set_op_t;

   function automatic logic coord_ok(input logic [3:0] c);
      return (c >= GRID_MIN) && (c <= GRID_MAX);
   endfunction

   // Only circles that participate in the selected mode must lie on the grid.
   function automatic logic range_ok(input set_op_t op);
      logic a_ok, b_ok, c_ok, ok;
      a_ok = coord_ok(op.central[23:20]) && coord_ok(op.central[19:16]);
      b_ok = coord_ok(op.central[15:12]) && coord_ok(op.central[11:8]);
      c_ok = coord_ok(op.central[7:4])   && coord_ok(op.central[3:0]);
      case (op.mode)
         MODE_A:            ok = a_ok;
         MODE_AND, MODE_XOR: ok = a_ok && b_ok;
         default:           ok = a_ok && b_ok && c_ok;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/set_query_sched_fifo.sv
// Generic synchronous FIFO; pushes are dropped when full, pops ignored when empty.
module set_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/set_query_sched.sv
// Issues buffered set queries to the SET engine one at a time and returns
// the engine count with the request tag and an error code.
module set_query_sched
   import set_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [23:0]      req_central,
   input  logic [11:0]      req_radius,
   input  logic [1:0]       req_mode,
   input  logic [TAG_W-1:0] req_tag,
   output logic             set_en,
   output logic [23:0]      set_central,
   output logic [11:0]      set_radius,
   output logic [1:0]       set_mode,
   input  logic             set_busy,
   input  logic             set_valid,
   input  logic [7:0]       set_candidate,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_candidate,
   output logic [TAG_W-1:0] res_tag,
   output logic [1:0]       res_err
);

   localparam int OPW = $bits(set_op_t);
   localparam int RW  = OPW + TAG_W;
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e           state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic [TAG_W-1:0] hold_tag, hold_tag_n;
   logic [RW-1:0]    head;
   set_op_t          head_op;
   logic [TAG_W-1:0] head_tag;
   logic             fifo_full, fifo_empty, pop;

   logic             set_en_n;
   logic [23:0]      set_central_n;
   logic [11:0]      set_radius_n;
   logic [1:0]       set_mode_n;
   logic             res_valid_n;
   logic [7:0]       res_candidate_n;
   logic [TAG_W-1:0] res_tag_n;
   logic [1:0]       res_err_n;

   assign req_ready = !fifo_full;
   assign head_op   = set_op_t'(head[OPW-1:0]);
   assign head_tag  = head[RW-1 -: TAG_W];

   set_req_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(RW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .pop   (pop),
      .wdata ({req_tag, req_central, req_radius, req_mode}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         hold_tag      <= '0;
         set_en        <= 1'b0;
         set_central   <= '0;
         set_radius    <= '0;
         set_mode      <= '0;
         res_valid     <= 1'b0;
         res_candidate <= '0;
         res_tag       <= '0;
         res_err       <= '0;
      end else begin
         state         <= state_n;
         timer         <= timer_n;
         hold_tag      <= hold_tag_n;
         set_en        <= set_en_n;
         set_central   <= set_central_n;
         set_radius    <= set_radius_n;
         set_mode      <= set_mode_n;
         res_valid     <= res_valid_n;
         res_candidate <= res_candidate_n;
         res_tag       <= res_tag_n;
         res_err       <= res_err_n;
      end
   end

   // The set_* registers double as the hold registers, so operands only move on a pop.
   always_comb begin
      state_n         = state;
      timer_n         = timer;
      hold_tag_n      = hold_tag;
      pop             = 1'b0;
      set_en_n        = 1'b0;
      set_central_n   = set_central;
      set_radius_n    = set_radius;
      set_mode_n      = set_mode;
      res_valid_n     = res_valid;
      res_candidate_n = res_candidate;
      res_tag_n       = res_tag;
      res_err_n       = res_err;

      case (state)
         IDLE: begin
            if (!fifo_empty && !set_busy) begin
               pop           = 1'b1;
               set_central_n = head_op.central;
               set_radius_n  = head_op.radius;
               set_mode_n    = head_op.mode;
               hold_tag_n    = head_tag;
               if (range_ok(head_op)) begin
                  set_en_n = 1'b1;
                  state_n  = ISSUE;
               end else begin
                  res_valid_n     = 1'b1;
                  res_candidate_n = '0;
                  res_tag_n       = head_tag;
                  res_err_n       = ERR_RANGE;
                  state_n         = RESP;
               end
            end
         end
         ISSUE: begin
            timer_n = '0;
            state_n = WAIT;
         end
         WAIT: begin
            timer_n = timer + 1'b1;
            if (set_valid && !set_busy) begin
               res_valid_n     = 1'b1;
               res_candidate_n = set_candidate;
               res_tag_n       = hold_tag;
               res_err_n       = ERR_OK;
               state_n         = RESP;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               res_valid_n     = 1'b1;
               res_candidate_n = '0;
               res_tag_n       = hold_tag;
               res_err_n       = ERR_TIMEOUT;
               state_n         = RESP;
            end
         end
         RESP: begin
            if (res_ready) begin
               res_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
